// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// bounded hold time with preemption, and a guard cycle between grants.
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             preempt_q, preempt_d;
    logic [2:0]       last_idx_q, last_idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [15:0] req_dbl;
    logic [3:0]  rot_sh;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;
    logic [7:0]  win_dec;
    logic        any_req;
    logic        others;
    logic        hold_done;

    // Rotate so bit 0 is the requester just after the last owner.
    always_comb begin
        req_dbl = {req, req};
        rot_sh  = {1'b0, last_idx_q} + 4'd1;
        req_rot = 8'(req_dbl >> rot_sh);
        win_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 3'(k);
            end
        end
        win_idx = last_idx_q + 3'd1 + win_off;
        any_req = |req;
    end

    always_comb begin
        win_dec = 8'd0;
        unique case (win_idx)
            3'd0: win_dec = 8'b0000_0001;
            3'd1: win_dec = 8'b0000_0010;
            3'd2: win_dec = 8'b0000_0100;
            3'd3: win_dec = 8'b0000_1000;
            3'd4: win_dec = 8'b0001_0000;
            3'd5: win_dec = 8'b0010_0000;
            3'd6: win_dec = 8'b0100_0000;
            3'd7: win_dec = 8'b1000_0000;
            default: win_dec = 8'd0;
        endcase
    end

    assign others    = |(req & ~gnt_q);
    assign hold_done = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
        last_idx_d  = last_idx_q;
        hold_cnt_d  = hold_cnt_q;
        unique case (state_q)
            IDLE, GAP: begin
                if (any_req) begin
                    state_d     = GRANT;
                    gnt_d       = win_dec;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    last_idx_d  = win_idx;
                    hold_cnt_d  = '0;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                // Release wins over timeout, so no preempt pulse then.
                if (!req[gnt_idx_q]) begin
                    state_d     = GAP;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                end else if (hold_done && others) begin
                    state_d     = GAP;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                    preempt_d   = 1'b1;
                end else if (!hold_done) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 8'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            last_idx_q  <= 3'd7;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            last_idx_q  <= last_idx_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios plus random requests
// compared cycle by cycle against a behavioural arbiter model.
module tb_rr_decode_arbiter;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_pass = 0;
    int n_total = 0;

    rr_decode_arbiter #(
        .MAX_HOLD(MH),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: owner, cycles held so far, last owner.
    bit m_valid;
    bit m_preempt;
    int m_owner;
    int m_held;
    int m_last;

    function automatic void m_reset();
        m_valid = 0;
        m_preempt = 0;
        m_owner = 0;
        m_held = 0;
        m_last = 7;
    endfunction

    function automatic void m_step(input logic [7:0] r);
        logic [7:0] oth;
        if (m_valid) begin
            oth = r & ~(8'h01 << m_owner);
            if (!r[m_owner]) begin
                m_valid = 0;
                m_preempt = 0;
            end else if (m_held >= MH && oth != 8'h00) begin
                m_valid = 0;
                m_preempt = 1;
            end else begin
                m_held++;
                m_preempt = 0;
            end
        end else begin
            m_preempt = 0;
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (r[c]) begin
                    m_valid = 1;
                    m_owner = c;
                    m_last = c;
                    m_held = 1;
                    break;
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) m_reset();
        else m_step(req);
        #1;
        chk("gnt", gnt, m_valid ? (1 << m_owner) : 0);
        chk("gnt_valid", gnt_valid, m_valid);
        chk("preempt", preempt, m_preempt);
        if (m_valid) chk("gnt_idx", gnt_idx, m_owner);
        chk("onehot", ($countones(gnt) <= 1), 1);
        chk("valid_eq_or", gnt_valid, |gnt);
        if (preempt) chk("preempt_in_gap", gnt_valid, 0);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order[$];
        int gaps[$];
        int held;
        int zeros;
        bit prev_v;

        rst = 1'b1;
        req = 8'h00;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_idx", gnt_idx, 0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_preempt", preempt, 0);
        tick();
        rst = 1'b0;

        // Single requester, held three edges then dropped
        tick();
        req = 8'h01;
        tick();
        chk("t1_gnt", gnt, 8'h01);
        chk("t1_idx", gnt_idx, 0);
        tick();
        tick();
        req = 8'h00;
        tick();
        chk("t1_rel_gnt", gnt, 0);
        chk("t1_rel_pre", preempt, 0);
        tick();
        chk("t1_idle", gnt_valid, 0);

        // All request; owners drop after two cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        held = 0;
        zeros = 0;
        prev_v = 0;
        for (int i = 0; i < 200 && order.size() < 9; i++) begin
            tick();
            if (gnt_valid) begin
                if (!prev_v) begin
                    order.push_back(int'(gnt_idx));
                    gaps.push_back(zeros);
                    held = 0;
                end
                held++;
                if (held == 2) req[gnt_idx] = 1'b0;
                zeros = 0;
            end else begin
                zeros++;
                req = 8'hFF;
            end
            prev_v = gnt_valid;
        end
        chk("t2_count", order.size(), 9);
        foreach (order[i]) begin
            chk("t2_order", order[i], i % 8);
            if (i > 0) chk("t2_gap", gaps[i], 1);
        end
        req = 8'h00;
        tick();
        tick();

        // Timeout preemption between requesters 3 and 5
        req = 8'h08;
        tick();
        chk("t3_gnt_c1", gnt, 8'h08);
        req = 8'h28;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("t3_gnt3", gnt, 8'h08);
            chk("t3_nopre", preempt, 0);
        end
        tick();
        chk("t3_pre", preempt, 1);
        chk("t3_pre_gnt", gnt, 0);
        tick();
        chk("t3_gnt5", gnt, 8'h20);
        chk("t3_pre_off", preempt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_gnt5_hold", gnt, 8'h20);
        end
        tick();
        chk("t3_pre2", preempt, 1);
        tick();
        chk("t3_regrant3", gnt, 8'h08);
        req = 8'h00;
        tick();
        tick();

        // Lone requester keeps grant past hold limit
        req = 8'h04;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("t4_gnt2", gnt, 8'h04);
            chk("t4_nopre", preempt, 0);
        end
        req = 8'h44;
        tick();
        chk("t4_pre", preempt, 1);
        chk("t4_pre_gnt", gnt, 0);
        tick();
        chk("t4_gnt6", gnt, 8'h40);
        req = 8'h00;
        tick();
        tick();

        // Asynchronous reset during a grant
        req = 8'h10;
        tick();
        chk("t5_gnt4", gnt, 8'h10);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_gnt", gnt, 0);
        chk("t5_async_valid", gnt_valid, 0);
        chk("t5_async_idx", gnt_idx, 0);
        req = 8'h11;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t5_first_gnt", gnt, 8'h01);
        chk("t5_first_idx", gnt_idx, 0);
        req = 8'h00;
        tick();
        tick();

        // Release coincides with timeout
        req = 8'h02;
        tick();
        chk("t6_gnt1", gnt, 8'h02);
        req = 8'h12;
        tick();
        tick();
        tick();
        chk("t6_gnt1_c4", gnt, 8'h02);
        req = 8'h10;
        tick();
        chk("t6_gap_gnt", gnt, 0);
        chk("t6_gap_pre", preempt, 0);
        tick();
        chk("t6_gnt4", gnt, 8'h10);
        req = 8'h00;
        tick();
        tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(499) == 0) begin
                #3;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        req = 8'h00;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Picks a 3-bit owner index and drives a registered one-hot grant, equal to 1 << index, matching the team's 3-to-8 decoder convention.
- Each grant has a bounded hold time. A guard cycle separates consecutive grants.
- Sits between requesting units and a shared select bus or mux.

Parameters:
- MAX_HOLD, 16: maximum grant cycles before preemption when another requester is waiting. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req, input, 8: request vector. req[i] high means requester i wants or holds the resource.
- gnt, output, 8: one-hot grant, registered. Equals 1 << gnt_idx while gnt_valid=1, else 0.
- gnt_idx, output, 3: index of the current owner, registered.
- gnt_valid, output, 1: high while a grant is active.
- preempt, output, 1: one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async assert, any time, including mid-grant):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, hold_cnt=0.
  - Internal last_idx=7, so the first search starts at requester 0.
  - Outputs clear immediately on rst assertion, not at the next edge.
- All outputs are registered. No combinational path from req to gnt.
- Arbitration function:
  - Candidate order is (last_idx+1+k) mod 8, for k=0..7.
  - The first candidate with req set wins.
  - Wrap-around from 7 to 0 is required.
- States:
  - IDLE:
    - Outputs gnt=0, gnt_valid=0.
    - On an edge with |req=1: winner w is chosen. Next cycle: GRANT, gnt=1<<w, gnt_idx=w, gnt_valid=1, last_idx=w, hold_cnt=0.
    - Latency from req sampled to gnt visible is one clock.
  - GRANT:
    - hold_cnt increments each cycle, saturating at MAX_HOLD-1.
    - Release: req[gnt_idx]=0 sampled. Next cycle: GAP, gnt=0, gnt_valid=0, preempt=0.
    - Timeout: hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0. Next cycle: GAP, gnt=0, gnt_valid=0, preempt=1 for that one cycle.
    - Release and timeout in the same cycle: treat as release, so preempt=0.
    - At timeout with no other requester: keep the grant, hold_cnt stays saturated. Preempt as soon as any other req appears, evaluated on the next edge.
    - gnt_idx and gnt stay constant throughout GRANT.
  - GAP:
    - Exactly one guard cycle with gnt=0.
    - On the GAP edge, arbitration runs as in IDLE. Any request leads to GRANT next cycle; none leads to IDLE.
    - A preempted requester still asserting req competes normally. Because last_idx equals its own index, it has lowest priority.
- Minimum spacing between two grants is one cycle with gnt=0. Back-to-back grants are impossible.
- A requester dropping req while not granted is harmless, since nothing is latched. Requests are level-sensitive only.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - preempt is only high when gnt_valid=0.

Test Plan:
- Reset then req=8'b0000_0001 held 3 cycles, then dropped:
  - gnt=8'h01 and gnt_idx=0 one cycle after the first sampled req.
  - gnt=0 the cycle after req[0] is sampled low.
  - Then IDLE.
- req=8'hFF held, each owner dropping its req after 2 grant cycles and re-raising it in GAP:
  - Grant order 0,1,2,…,7,0.
  - Exactly one gnt=0 cycle between grants; wrap-around from 7 to 0 confirmed.
- MAX_HOLD=4, req[3] held forever, req[5] raised at grant cycle 1:
  - gnt=8'h08 for 4 cycles.
  - preempt=1 with gnt=0 for 1 cycle.
  - Then gnt=8'h20.
  - With req[5] held, requester 3 is re-granted after requester 5's 4-cycle hold.
- MAX_HOLD=4, only req[2] held for 20 cycles:
  - gnt=8'h04 for all 20 cycles; preempt never asserted.
  - req[6] raised at cycle 20 leads to preempt pulse then gnt=8'h40.
- Mid-grant reset:
  - Assert rst asynchronously between edges during gnt=8'h10.
  - gnt, gnt_valid and gnt_idx go to 0 immediately.
  - After deassert with req=8'h11, the first grant goes to requester 0 (last_idx=7).
- Release and timeout coincide (MAX_HOLD=4; req[1] drops on its 4th grant cycle; req[4] pending):
  - preempt stays 0.
  - One GAP cycle, then gnt=8'h10.
